// File: rtl/pipe_mips32.sv
// pipe_mips32: five-stage (IF/ID/EX/MEM/WB) MIPS32-subset core with a unified word-addressed
// instruction/data memory and a 32x32 register file. No forwarding or hazard detection.
// A single clock runs two phases: posedge drives IF, EX and WB; negedge drives ID and MEM.
//
// Ports:
//   clk    - single clock
//   rst_n  - asynchronous active-low reset (memory contents are not reset)
//   halted - high once an HLT instruction has reached WB; held until reset
module pipe_mips32 #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic halted
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b000001;
    localparam logic [5:0] OpAnd   = 6'b000010;
    localparam logic [5:0] OpOr    = 6'b000011;
    localparam logic [5:0] OpSlt   = 6'b000100;
    localparam logic [5:0] OpMul   = 6'b000101;
    localparam logic [5:0] OpLw    = 6'b001000;
    localparam logic [5:0] OpSw    = 6'b001001;
    localparam logic [5:0] OpAddi  = 6'b001010;
    localparam logic [5:0] OpSubi  = 6'b001011;
    localparam logic [5:0] OpSlti  = 6'b001100;
    localparam logic [5:0] OpBneqz = 6'b001101;
    localparam logic [5:0] OpBeqz  = 6'b001110;
    localparam logic [5:0] OpHlt   = 6'b111111;

    logic [31:0] Mem [0:MEM_DEPTH-1];
    logic [31:0] Reg [0:31];
    logic [31:0] PC, pc_d;
    logic        HALTED, halted_d;
    logic        TAKEN_BRANCH, taken_branch_d;

    // The *_sq flags mark the one instruction fetched alongside a taken branch's EX.
    logic [31:0] if_id_ir_q, if_id_ir_d, if_id_npc_q, if_id_npc_d;
    logic        if_id_sq_q, if_id_sq_d;

    logic [5:0]  id_ex_op_q, id_ex_op_d;
    logic [4:0]  id_ex_rt_q, id_ex_rt_d, id_ex_rd_q, id_ex_rd_d;
    logic [31:0] id_ex_npc_q, id_ex_npc_d, id_ex_a_q, id_ex_a_d;
    logic [31:0] id_ex_b_q, id_ex_b_d, id_ex_imm_q, id_ex_imm_d;
    logic        id_ex_sq_q, id_ex_sq_d;

    logic [5:0]  ex_mem_op_q, ex_mem_op_d;
    logic [4:0]  ex_mem_rt_q, ex_mem_rt_d, ex_mem_rd_q, ex_mem_rd_d;
    logic [31:0] ex_mem_alu_q, ex_mem_alu_d, ex_mem_b_q, ex_mem_b_d;
    logic        ex_mem_cond_q, ex_mem_cond_d, ex_mem_sq_q, ex_mem_sq_d;

    logic [5:0]  mem_wb_op_q, mem_wb_op_d;
    logic [4:0]  mem_wb_rt_q, mem_wb_rt_d, mem_wb_rd_q, mem_wb_rd_d;
    logic [31:0] mem_wb_alu_q, mem_wb_alu_d, mem_wb_lmd_q, mem_wb_lmd_d;
    logic        mem_wb_sq_q, mem_wb_sq_d;

    logic [31:0] fetch_pc, ex_alu, reg_wdata;
    logic        ex_taken, mem_we, reg_we;
    logic [4:0]  reg_dst;

    function automatic logic [AW-1:0] widx(input logic [31:0] addr);
        return AW'(addr % 32'(MEM_DEPTH));
    endfunction

    assign halted = HALTED;

    // IF: ex_mem_cond_q is a taken branch resolved on the previous posedge.
    always_comb begin
        fetch_pc    = ex_mem_cond_q ? ex_mem_alu_q : PC;
        pc_d        = PC;
        if_id_ir_d  = if_id_ir_q;
        if_id_npc_d = if_id_npc_q;
        if_id_sq_d  = if_id_sq_q;
        if (!HALTED) begin
            pc_d        = fetch_pc + 32'd1;
            if_id_ir_d  = Mem[widx(fetch_pc)];
            if_id_npc_d = fetch_pc + 32'd1;
            if_id_sq_d  = ex_taken;
        end
    end

    // ID
    always_comb begin
        id_ex_op_d  = id_ex_op_q;
        id_ex_rt_d  = id_ex_rt_q;
        id_ex_rd_d  = id_ex_rd_q;
        id_ex_npc_d = id_ex_npc_q;
        id_ex_a_d   = id_ex_a_q;
        id_ex_b_d   = id_ex_b_q;
        id_ex_imm_d = id_ex_imm_q;
        id_ex_sq_d  = id_ex_sq_q;
        if (!HALTED) begin
            id_ex_op_d  = if_id_ir_q[31:26];
            id_ex_rt_d  = if_id_ir_q[20:16];
            id_ex_rd_d  = if_id_ir_q[15:11];
            id_ex_npc_d = if_id_npc_q;
            id_ex_a_d   = (if_id_ir_q[25:21] == 5'd0) ? 32'd0 : Reg[if_id_ir_q[25:21]];
            id_ex_b_d   = (if_id_ir_q[20:16] == 5'd0) ? 32'd0 : Reg[if_id_ir_q[20:16]];
            id_ex_imm_d = {{16{if_id_ir_q[15]}}, if_id_ir_q[15:0]};
            id_ex_sq_d  = if_id_sq_q;
        end
    end

    // EX
    always_comb begin
        case (id_ex_op_q)
            OpAdd:               ex_alu = id_ex_a_q + id_ex_b_q;
            OpSub:               ex_alu = id_ex_a_q - id_ex_b_q;
            OpAnd:               ex_alu = id_ex_a_q & id_ex_b_q;
            OpOr:                ex_alu = id_ex_a_q | id_ex_b_q;
            OpSlt:               ex_alu = {31'd0, $signed(id_ex_a_q) < $signed(id_ex_b_q)};
            OpMul:               ex_alu = id_ex_a_q * id_ex_b_q;
            OpAddi, OpLw, OpSw:  ex_alu = id_ex_a_q + id_ex_imm_q;
            OpSubi:              ex_alu = id_ex_a_q - id_ex_imm_q;
            OpSlti:              ex_alu = {31'd0, $signed(id_ex_a_q) < $signed(id_ex_imm_q)};
            OpBneqz, OpBeqz:     ex_alu = id_ex_npc_q + id_ex_imm_q;
            default:             ex_alu = 32'd0;
        endcase
        ex_taken = !id_ex_sq_q && ((id_ex_op_q == OpBeqz && id_ex_a_q == 32'd0) ||
                                   (id_ex_op_q == OpBneqz && id_ex_a_q != 32'd0));
    end

    always_comb begin
        ex_mem_op_d    = ex_mem_op_q;
        ex_mem_rt_d    = ex_mem_rt_q;
        ex_mem_rd_d    = ex_mem_rd_q;
        ex_mem_alu_d   = ex_mem_alu_q;
        ex_mem_b_d     = ex_mem_b_q;
        ex_mem_cond_d  = ex_mem_cond_q;
        ex_mem_sq_d    = ex_mem_sq_q;
        taken_branch_d = TAKEN_BRANCH;
        if (!HALTED) begin
            ex_mem_op_d   = id_ex_op_q;
            ex_mem_rt_d   = id_ex_rt_q;
            ex_mem_rd_d   = id_ex_rd_q;
            ex_mem_alu_d  = ex_alu;
            ex_mem_b_d    = id_ex_b_q;
            ex_mem_cond_d = ex_taken;
            ex_mem_sq_d   = id_ex_sq_q;
            // The squashed slot keeps the flag up; the branch target is the next live entrant.
            if (ex_taken) begin
                taken_branch_d = 1'b1;
            end else if (!id_ex_sq_q) begin
                taken_branch_d = 1'b0;
            end
        end
    end

    // MEM
    always_comb begin
        mem_we       = !HALTED && !ex_mem_sq_q && (ex_mem_op_q == OpSw);
        mem_wb_op_d  = mem_wb_op_q;
        mem_wb_rt_d  = mem_wb_rt_q;
        mem_wb_rd_d  = mem_wb_rd_q;
        mem_wb_alu_d = mem_wb_alu_q;
        mem_wb_lmd_d = mem_wb_lmd_q;
        mem_wb_sq_d  = mem_wb_sq_q;
        if (!HALTED) begin
            mem_wb_op_d  = ex_mem_op_q;
            mem_wb_rt_d  = ex_mem_rt_q;
            mem_wb_rd_d  = ex_mem_rd_q;
            mem_wb_alu_d = ex_mem_alu_q;
            mem_wb_lmd_d = Mem[widx(ex_mem_alu_q)];
            mem_wb_sq_d  = ex_mem_sq_q;
        end
    end

    // WB: frozen once halted so nothing younger than HLT commits.
    always_comb begin
        reg_we    = 1'b0;
        reg_dst   = mem_wb_rd_q;
        reg_wdata = mem_wb_alu_q;
        halted_d  = HALTED;
        if (!HALTED && !mem_wb_sq_q) begin
            case (mem_wb_op_q)
                OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul: reg_we = 1'b1;
                OpAddi, OpSubi, OpSlti: begin
                    reg_we  = 1'b1;
                    reg_dst = mem_wb_rt_q;
                end
                OpLw: begin
                    reg_we    = 1'b1;
                    reg_dst   = mem_wb_rt_q;
                    reg_wdata = mem_wb_lmd_q;
                end
                OpHlt:   halted_d = 1'b1;
                default: reg_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC            <= '0;
            HALTED        <= 1'b0;
            TAKEN_BRANCH  <= 1'b0;
            if_id_ir_q    <= '0;
            if_id_npc_q   <= '0;
            if_id_sq_q    <= 1'b0;
            ex_mem_op_q   <= '0;
            ex_mem_rt_q   <= '0;
            ex_mem_rd_q   <= '0;
            ex_mem_alu_q  <= '0;
            ex_mem_b_q    <= '0;
            ex_mem_cond_q <= 1'b0;
            ex_mem_sq_q   <= 1'b0;
        end else begin
            PC            <= pc_d;
            HALTED        <= halted_d;
            TAKEN_BRANCH  <= taken_branch_d;
            if_id_ir_q    <= if_id_ir_d;
            if_id_npc_q   <= if_id_npc_d;
            if_id_sq_q    <= if_id_sq_d;
            ex_mem_op_q   <= ex_mem_op_d;
            ex_mem_rt_q   <= ex_mem_rt_d;
            ex_mem_rd_q   <= ex_mem_rd_d;
            ex_mem_alu_q  <= ex_mem_alu_d;
            ex_mem_b_q    <= ex_mem_b_d;
            ex_mem_cond_q <= ex_mem_cond_d;
            ex_mem_sq_q   <= ex_mem_sq_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) Reg[i] <= '0;
        end else if (reg_we && reg_dst != 5'd0) begin
            Reg[reg_dst] <= reg_wdata;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_op_q   <= '0;
            id_ex_rt_q   <= '0;
            id_ex_rd_q   <= '0;
            id_ex_npc_q  <= '0;
            id_ex_a_q    <= '0;
            id_ex_b_q    <= '0;
            id_ex_imm_q  <= '0;
            id_ex_sq_q   <= 1'b0;
            mem_wb_op_q  <= '0;
            mem_wb_rt_q  <= '0;
            mem_wb_rd_q  <= '0;
            mem_wb_alu_q <= '0;
            mem_wb_lmd_q <= '0;
            mem_wb_sq_q  <= 1'b0;
        end else begin
            id_ex_op_q   <= id_ex_op_d;
            id_ex_rt_q   <= id_ex_rt_d;
            id_ex_rd_q   <= id_ex_rd_d;
            id_ex_npc_q  <= id_ex_npc_d;
            id_ex_a_q    <= id_ex_a_d;
            id_ex_b_q    <= id_ex_b_d;
            id_ex_imm_q  <= id_ex_imm_d;
            id_ex_sq_q   <= id_ex_sq_d;
            mem_wb_op_q  <= mem_wb_op_d;
            mem_wb_rt_q  <= mem_wb_rt_d;
            mem_wb_rd_q  <= mem_wb_rd_d;
            mem_wb_alu_q <= mem_wb_alu_d;
            mem_wb_lmd_q <= mem_wb_lmd_d;
            mem_wb_sq_q  <= mem_wb_sq_d;
        end
    end

    // Memory is deliberately left out of reset.
    always_ff @(negedge clk) begin
        if (mem_we) begin
            Mem[widx(ex_mem_alu_q)] <= ex_mem_b_q;
        end
    end

endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32: loads small programs into pipe_mips32 memory, runs each to HLT and compares
// register/memory results queued in a scoreboard when the program is loaded.
module tb_pipe_mips32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halted;

    pipe_mips32 #(.MEM_DEPTH(1024)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .halted (halted)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] TAdd = 6'b000000, TSub = 6'b000001, TAnd = 6'b000010;
    localparam logic [5:0] TOr = 6'b000011, TSlt = 6'b000100, TMul = 6'b000101;
    localparam logic [5:0] TLw = 6'b001000, TSw = 6'b001001, TAddi = 6'b001010;
    localparam logic [5:0] TSubi = 6'b001011, TSlti = 6'b001100, TBneqz = 6'b001101;
    localparam logic [5:0] TBeqz = 6'b001110;
    localparam logic [31:0] Nop = 32'h4000_0000;
    localparam logic [31:0] Hlt = 32'hfc00_0000;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic        is_mem;
        int          idx;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        is_imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[15];

    logic [31:0] prog[$];

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt,
                                          input int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic expect_reg(input string name, input int idx, input logic [31:0] exp);
        sb_q.push_back('{name, 1'b0, idx, exp});
    endtask

    task automatic expect_mem(input string name, input int idx, input logic [31:0] exp);
        sb_q.push_back('{name, 1'b1, idx, exp});
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx], e.exp);
        end
    endtask

    function automatic int nonzero_regs();
        int n = 0;
        for (int i = 0; i < 32; i++) if (dut.Reg[i] != 32'd0) n++;
        return n;
    endfunction

    // Holds the core in reset while the program image is written.
    task automatic load_prog();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) dut.Mem[i] = Nop;
        foreach (prog[i]) dut.Mem[i] = prog[i];
    endtask

    task automatic run(input string name, input int budget);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (halted) break;
            @(posedge clk);
        end
        #1;
        check({name, "_halted"}, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        #1;
        check("rst_pc", dut.PC, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        check("rst_regs", 32'(nonzero_regs()), 32'd0);

        vecs[0]  = '{"add",       TAdd,  1'b0, 32'd5,        32'd7,        16'h0,    32'd12};
        vecs[1]  = '{"add_wrap",  TAdd,  1'b0, 32'hffffffff, 32'd1,        16'h0,    32'd0};
        vecs[2]  = '{"sub_neg",   TSub,  1'b0, 32'd3,        32'd5,        16'h0,    32'hfffffffe};
        vecs[3]  = '{"and",       TAnd,  1'b0, 32'hf0f000ff, 32'h0ff0f00f, 16'h0,    32'h00f0000f};
        vecs[4]  = '{"or",        TOr,   1'b0, 32'hf0000000, 32'h0000000f, 16'h0,    32'hf000000f};
        vecs[5]  = '{"slt_neg",   TSlt,  1'b0, 32'hffffffff, 32'd1,        16'h0,    32'd1};
        vecs[6]  = '{"slt_false", TSlt,  1'b0, 32'd5,        32'd3,        16'h0,    32'd0};
        vecs[7]  = '{"slt_min",   TSlt,  1'b0, 32'h80000000, 32'h7fffffff, 16'h0,    32'd1};
        vecs[8]  = '{"mul_wrap",  TMul,  1'b0, 32'h00010000, 32'h00010000, 16'h0,    32'd0};
        vecs[9]  = '{"mul_neg",   TMul,  1'b0, 32'd7,        32'hfffffffd, 16'h0,    32'hffffffeb};
        vecs[10] = '{"addi_neg",  TAddi, 1'b1, 32'd10,       32'd0,        16'hffff, 32'd9};
        vecs[11] = '{"subi",      TSubi, 1'b1, 32'd10,       32'd0,        16'h0003, 32'd7};
        vecs[12] = '{"subi_neg",  TSubi, 1'b1, 32'd1,        32'd0,        16'hffff, 32'd2};
        vecs[13] = '{"slti_true", TSlti, 1'b1, 32'hfffffffb, 32'd0,        16'hfffe, 32'd1};
        vecs[14] = '{"slti_eq",   TSlti, 1'b1, 32'd4,        32'd0,        16'h0004, 32'd0};

        // Operands arrive by LW so full 32-bit values can be exercised.
        foreach (vecs[v]) begin
            prog = {enc_i(TLw, 0, 1, 16'd200), enc_i(TLw, 0, 2, 16'd201), Nop,
                    vecs[v].is_imm ? enc_i(vecs[v].op, 1, 3, vecs[v].imm)
                                   : enc_r(vecs[v].op, 1, 2, 3),
                    Nop, enc_i(TSw, 0, 3, 16'd202), Hlt};
            load_prog();
            dut.Mem[200] = vecs[v].a;
            dut.Mem[201] = vecs[v].b;
            dut.Mem[202] = 32'hdeadbeef;
            expect_reg({vecs[v].name, "_r3"}, 3, vecs[v].exp);
            expect_mem({vecs[v].name, "_mem"}, 202, vecs[v].exp);
            run(vecs[v].name, 100);
            drain();
        end

        prog = {32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        load_prog();
        dut.Mem[120] = 32'd85;
        dut.Mem[121] = 32'd0;
        expect_mem("lwsw_m120", 120, 32'd85);
        expect_mem("lwsw_m121", 121, 32'd130);
        expect_reg("lwsw_r1", 1, 32'd120);
        expect_reg("lwsw_r2", 2, 32'd130);
        run("lwsw", 50);
        drain();

        prog = {enc_i(TAddi, 0, 1, 16'd10), enc_r(TOr, 20, 20, 20),
                enc_i(TAddi, 0, 2, 16'd20), enc_r(TOr, 20, 20, 20),
                enc_i(TAddi, 0, 3, 16'd25), enc_r(TOr, 20, 20, 20),
                enc_r(TAdd, 1, 2, 4), enc_r(TOr, 20, 20, 20),
                enc_r(TSub, 3, 1, 5), enc_r(TOr, 20, 20, 20),
                enc_r(TSlt, 1, 2, 6), enc_r(TOr, 20, 20, 20),
                enc_r(TMul, 1, 3, 7), Hlt};
        load_prog();
        expect_reg("seq_r4", 4, 32'd30);
        expect_reg("seq_r5", 5, 32'd15);
        expect_reg("seq_r6", 6, 32'd1);
        expect_reg("seq_r7", 7, 32'd250);
        run("seq", 100);
        drain();

        // Taken branch: slot squashed, skipped instruction never fetched.
        prog = {enc_i(TAddi, 0, 1, 16'd0), Nop, enc_i(TBeqz, 1, 0, 16'd2),
                enc_i(TAddi, 0, 2, 16'd7), enc_i(TAddi, 0, 2, 16'd9),
                enc_i(TAddi, 0, 3, 16'd5), Hlt};
        load_prog();
        expect_reg("beqz_r2", 2, 32'd0);
        expect_reg("beqz_r3", 3, 32'd5);
        run("beqz", 100);
        drain();
        check("beqz_taken_clr", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

        prog[2] = enc_i(TBneqz, 1, 0, 16'd2);
        load_prog();
        expect_reg("bneqz_r2", 2, 32'd9);
        expect_reg("bneqz_r3", 3, 32'd5);
        run("bneqz", 100);
        drain();

        // HLT in the squashed slot must not halt the core.
        prog = {Nop, Nop, enc_i(TBeqz, 0, 0, 16'd1), Hlt,
                enc_i(TAddi, 0, 3, 16'd5), Nop, Hlt};
        load_prog();
        expect_reg("slot_hlt_r3", 3, 32'd5);
        run("slot_hlt", 100);
        drain();

        prog = {enc_i(TAddi, 0, 0, 16'd55), Hlt, enc_i(TAddi, 0, 1, 16'd3)};
        load_prog();
        expect_reg("hlt_r0", 0, 32'd0);
        expect_reg("hlt_r1", 1, 32'd0);
        run("hlt", 100);
        repeat (5) @(posedge clk);
        #1;
        drain();
        check("hlt_pc_frozen", dut.PC, 32'd4);
        check("hlt_stays", {31'd0, halted}, 32'd1);

        // Reset in the middle of the LW/SW program, then restart from Mem[0].
        prog = {32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        load_prog();
        dut.Mem[120] = 32'd85;
        dut.Mem[121] = 32'd0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("mid_r1", dut.Reg[1], 32'd120);
        rst_n = 1'b0;
        #1;
        check("arst_pc", dut.PC, 32'd0);
        check("arst_halted", {31'd0, halted}, 32'd0);
        check("arst_regs", 32'(nonzero_regs()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("arst_hold_regs", 32'(nonzero_regs()), 32'd0);
        check("arst_hold_pc", dut.PC, 32'd0);
        expect_mem("rerun_m121", 121, 32'd130);
        expect_reg("rerun_r1", 1, 32'd120);
        expect_reg("rerun_r2", 2, 32'd130);
        run("rerun", 50);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_mips32.md
Name: pipe_mips32

Overview:
- Five-stage pipelined MIPS32-subset processor (IF, ID, EX, MEM, WB) with a unified word-addressed instruction/data memory and a 32x32 register file.
- Top-level CPU core used for program-level tests. The bench preloads memory and registers hierarchically, then lets the core run to HLT.
- No hazard detection or forwarding. Software inserts independent instructions between dependent ones.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the unified memory; word addresses wrap modulo MEM_DEPTH.

Ports:
- clk  input  1  single clock. Posedge drives IF, EX and WB; negedge drives ID and MEM (two-phase pipeline on one clock).
- rst_n  input  1  asynchronous active-low reset.
- halted  output  1  mirrors internal HALTED flag.

Behaviour:
- Hierarchically visible state, named exactly: Mem[0:MEM_DEPTH-1] (32b), Reg[0:31] (32b), PC (32b), HALTED, TAKEN_BRANCH. The bench may write any of these directly before running.
- Reset (rst_n low, async):
  - PC=0, HALTED=0, TAKEN_BRANCH=0.
  - All pipeline registers cleared; cleared IR acts as a NOP that commits nothing.
  - Reg[0..31]=0. Mem is NOT reset.
  - halted=0.
- Encoding:
  - opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] sign-extended to 32b.
  - R-type (rd <- rs op rt): ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101 (low 32 bits).
  - I-type ALU (rt <- rs op imm): ADDI 001010, SUBI 001011, SLTI 001100.
  - LW 001000: rt <- Mem[rs+imm].
  - SW 001001: Mem[rs+imm] <- rt.
  - BNEQZ 001101, BEQZ 001110: test rs; target = (branch address + 1) + imm.
  - HLT 111111.
  - Any other opcode is a NOP.
  - SLT/SLTI are signed compares producing 1 or 0. Arithmetic wraps modulo 2^32.
- Stage timing, each instruction spans 2.5 clock cycles:
  - IF at posedge k. ID at negedge k. EX at posedge k+1. MEM at negedge k+1. WB at posedge k+2.
  - One instruction is issued per cycle.
- Hazard spacing:
  - Register write in WB at posedge k+2 is visible to an ID at negedge k+2 or later.
  - A dependent instruction therefore needs at least one independent instruction between it and its producer. This applies to LW-use as well.
- Writes to Reg[0] are ignored; R0 always reads 0.
- Branches:
  - Condition is evaluated in EX.
  - If taken: TAKEN_BRANCH=1 and the next IF fetches from the target, with PC = target+1.
  - The single instruction fetched in the same cycle as the branch's EX is squashed: no register write, no memory write, no halt.
  - TAKEN_BRANCH clears when the first target instruction enters EX.
  - A not-taken branch has no effect.
- HLT:
  - When HLT reaches WB, HALTED=1.
  - IF, ID, EX and MEM then freeze (no state updates).
  - Instructions younger than HLT never commit.
  - HALTED stays 1 until reset.
- Memory is read combinationally within the stage's edge and written at MEM for SW.
- Reset mid-operation aborts all in-flight instructions immediately. Mem contents already written persist.

Test Plan:
- LW/SW program:
  - Program: Mem[0..7] = 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000. Initial data: Mem[120]=85.
  - Run 50 cycles -> Mem[120]=85, Mem[121]=130, R1=120, R2=130, halted=1.
- ALU sequence:
  - Stimulus: ADDI R1=10, ADDI R2=20, ADDI R3=25, each separated by a dummy OR; then ADD R4=R1+R2, SUB R5=R3-R1, SLT R6=R1<R2, MUL R7=R1*R3, each separated by dummies.
  - Required: R4=30, R5=15, R6=1, R7=250.
- Branch:
  - Stimulus: ADDI R1=0; dummy; BEQZ R1,+2; ADDI R2=7 (squashed); ADDI R2=9 (skipped); ADDI R3=5; HLT.
  - Required: R2=0, R3=5.
  - Same program with BNEQZ -> R2=9 and R3=5 (the slot instruction still executes because the branch is not taken, so R2 becomes 7 then 9).
- HLT / R0:
  - Stimulus: ADDI R0=55; HLT; ADDI R1=3.
  - Required: R0=0, R1=0, halted stays 1, PC frozen.
- Async reset:
  - Stimulus: assert rst_n low mid-program.
  - Required immediately: PC=0, halted=0, all Reg=0; no further commits while rst_n is low.
  - After release: execution restarts from Mem[0].
